// File: rtl/fft_cap_pkg.sv
// Shared configuration and FSM state encoding for the FFT bin capture sink.
package fft_cap_pkg;
    localparam int DW      = 15;
    localparam int LGSIZE  = 8;
    localparam int N       = 1 << LGSIZE;
    localparam int PEAK_LO = 1;
    localparam int PEAK_HI = 127;
    localparam int MAGW    = 2 * DW + 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SYNC,
        CAPTURE,
        DRAIN,
        HOLD
    } state_t;
endpackage

// File: rtl/fft_cap_magsq.sv
// Two-stage squared-magnitude pipeline; bin index and range flag ride alongside the data.
module fft_magsq #(
    parameter int DW     = fft_cap_pkg::DW,
    parameter int LGSIZE = fft_cap_pkg::LGSIZE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     vld_p0,
    input  logic                     rng_p0,
    input  logic [LGSIZE-1:0]        idx_p0,
    input  logic signed [DW-1:0]     re_p0,
    input  logic signed [DW-1:0]     im_p0,
    output logic                     vld_p2,
    output logic                     rng_p2,
    output logic [LGSIZE-1:0]        idx_p2,
    output logic [2*DW:0]            mag_p2
);
    import fft_cap_pkg::*;

    logic                     vld_p1;
    logic                     rng_p1;
    logic [LGSIZE-1:0]        idx_p1;
    logic signed [2*DW-1:0]   re_sq_p1;
    logic signed [2*DW-1:0]   im_sq_p1;

    // Square of the most negative input is 2^(2DW-2), still positive in 2DW signed bits.
    function automatic logic signed [2*DW-1:0] square(input logic signed [DW-1:0] x);
        logic signed [2*DW-1:0] xe;
        xe = {{DW{x[DW-1]}}, x};
        return xe * xe;
    endfunction

    function automatic logic [2*DW:0] mag_sum(input logic signed [2*DW-1:0] a,
                                              input logic signed [2*DW-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Flush drops whatever sat in stage 1 so a restarted frame never sees stale bins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1 & ~flush;
        end
    end

    // stage 1: products
    always_ff @(posedge clk) begin
        rng_p1   <= rng_p0;
        idx_p1   <= idx_p0;
        re_sq_p1 <= square(re_p0);
        im_sq_p1 <= square(im_p0);
    end

    // stage 2: unsigned magnitude sum
    always_ff @(posedge clk) begin
        rng_p2 <= rng_p1;
        idx_p2 <= idx_p1;
        mag_p2 <= mag_sum(re_sq_p1, im_sq_p1);
    end
endmodule

// File: rtl/fft_bin_capture.sv
// FFT output sink: per armed frame captures one bin and finds the peak |X|^2
// over the positive-frequency bins, presenting both on a valid/ready handshake.
module fft_bin_capture #(
    parameter int DW      = fft_cap_pkg::DW,
    parameter int LGSIZE  = fft_cap_pkg::LGSIZE,
    parameter int PEAK_LO = fft_cap_pkg::PEAK_LO,
    parameter int PEAK_HI = fft_cap_pkg::PEAK_HI
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_ce,
    input  logic                  i_sync,
    input  logic [2*DW-1:0]       i_result,
    input  logic                  i_arm,
    input  logic [LGSIZE-1:0]     i_bin,
    output logic                  o_busy,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic signed [DW-1:0]  o_bin_re,
    output logic signed [DW-1:0]  o_bin_im,
    output logic [LGSIZE-1:0]     o_peak_idx,
    output logic [2*DW:0]         o_peak_mag,
    output logic                  o_overrun
);
    import fft_cap_pkg::*;

    localparam logic [LGSIZE-1:0] BIN_LO = LGSIZE'(PEAK_LO);
    localparam logic [LGSIZE-1:0] BIN_HI = LGSIZE'(PEAK_HI);

    state_t                  state;
    state_t                  state_nx;
    logic [LGSIZE-1:0]       count;
    logic [LGSIZE-1:0]       sel_bin;
    logic [1:0]              drain_cnt;
    logic                    peak_found;

    logic                    vld_p0;
    logic                    restart;
    logic                    last_bin;
    logic                    rng_p0;
    logic [LGSIZE-1:0]       idx_p0;
    logic signed [DW-1:0]    re_p0;
    logic signed [DW-1:0]    im_p0;

    logic                    vld_p2;
    logic                    rng_p2;
    logic [LGSIZE-1:0]       idx_p2;
    logic [2*DW:0]           mag_p2;

    assign re_p0    = i_result[2*DW-1:DW];
    assign im_p0    = i_result[DW-1:0];
    // A sync in WAIT_SYNC starts the frame; a sync in CAPTURE restarts it.
    assign vld_p0   = i_ce && ((state == WAIT_SYNC && i_sync) || state == CAPTURE);
    assign restart  = vld_p0 && i_sync;
    assign idx_p0   = restart ? '0 : count;
    assign last_bin = vld_p0 && !i_sync && (&count);
    assign rng_p0   = (idx_p0 >= BIN_LO) && (idx_p0 <= BIN_HI);

    fft_magsq #(
        .DW     (DW),
        .LGSIZE (LGSIZE)
    ) u_magsq (
        .clk    (i_clk),
        .rst_n  (i_reset_n),
        .flush  (restart),
        .vld_p0 (vld_p0),
        .rng_p0 (rng_p0),
        .idx_p0 (idx_p0),
        .re_p0  (re_p0),
        .im_p0  (im_p0),
        .vld_p2 (vld_p2),
        .rng_p2 (rng_p2),
        .idx_p2 (idx_p2),
        .mag_p2 (mag_p2)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nx;
    end

    // DRAIN lasts until the last bin has left the magnitude pipeline and hit the peak regs.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (i_arm)               state_nx = WAIT_SYNC;
            WAIT_SYNC: if (vld_p0)              state_nx = CAPTURE;
            CAPTURE:   if (last_bin)            state_nx = DRAIN;
            DRAIN:     if (drain_cnt == 2'd2)   state_nx = HOLD;
            HOLD:      if (i_ready)             state_nx = IDLE;
            default:                            state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_busy  = (state == WAIT_SYNC) || (state == CAPTURE) || (state == DRAIN);
        o_valid = (state == HOLD);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count      <= '0;
            sel_bin    <= '0;
            drain_cnt  <= '0;
            o_bin_re   <= '0;
            o_bin_im   <= '0;
            o_peak_idx <= '0;
            o_peak_mag <= '0;
            peak_found <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            o_overrun <= (state == HOLD) && i_ce && i_sync;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;

            if (state == IDLE && i_arm) sel_bin <= i_bin;
            if (vld_p0)                 count   <= idx_p0 + LGSIZE'(1);

            if (vld_p0 && idx_p0 == sel_bin) begin
                o_bin_re <= re_p0;
                o_bin_im <= im_p0;
            end else if (restart) begin
                o_bin_re <= '0;
                o_bin_im <= '0;
            end

            // Strict compare keeps the lowest index on ties.
            if (restart) begin
                o_peak_idx <= '0;
                o_peak_mag <= '0;
                peak_found <= 1'b0;
            end else if (vld_p2 && rng_p2 && (!peak_found || mag_p2 > o_peak_mag)) begin
                o_peak_idx <= idx_p2;
                o_peak_mag <= mag_p2;
                peak_found <= 1'b1;
            end
        end
    end
endmodule
